// File: rtl/ocs_slot_sequencer.sv
// Slot-timing engine for the OCS controller: link-stable start, then a repeating
// SYNC -> SLOT -> CONFIG cycle over P_SLOT_NUM slot configurations.
module ocs_slot_sequencer #(
    parameter int          P_CHANNEL_NUM  = 8,
    parameter int          P_SLOT_NUM     = 2,
    parameter int          P_SLOT_ID_W    = 1,
    parameter logic [31:0] P_SLOT_LEN     = 32'h0000_0832,
    parameter logic [31:0] P_CONFIG_DELAY = 32'h0000_007D,
    parameter logic [15:0] P_LINK_STABLE  = 16'd1024,
    parameter logic [15:0] P_SYNC_TIMEOUT = 16'd4096
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_enable,
    input  logic [P_CHANNEL_NUM-1:0] i_link_up,
    input  logic [P_CHANNEL_NUM-1:0] i_sync_ready,
    output logic [P_CHANNEL_NUM-1:0] o_sync_valid,
    output logic [P_SLOT_ID_W-1:0]   o_sync_slot_id,
    output logic [P_SLOT_ID_W-1:0]   o_slot_id,
    output logic                     o_slot_valid,
    output logic                     o_ocs_reconfig,
    output logic                     o_sim_start,
    output logic                     o_link_err,
    output logic                     o_sync_timeout,
    output logic [31:0]              o_slot_cnt
);

    // Terminal counts; zero-length windows behave as one cycle.
    localparam logic [31:0] SLOT_LAST   = (P_SLOT_LEN == 32'd0) ? 32'd0 : P_SLOT_LEN - 32'd1;
    localparam logic [31:0] CFG_LAST    = (P_CONFIG_DELAY == 32'd0) ? 32'd0 : P_CONFIG_DELAY - 32'd1;
    localparam logic [15:0] STABLE_LAST = (P_LINK_STABLE == 16'd0) ? 16'd0 : P_LINK_STABLE - 16'd1;
    localparam logic [31:0] SYNC_LAST   = {16'd0, (P_SYNC_TIMEOUT == 16'd0) ? 16'd0 : P_SYNC_TIMEOUT - 16'd1};
    localparam logic [P_SLOT_ID_W-1:0] ID_LAST = P_SLOT_ID_W'(P_SLOT_NUM - 1);

    typedef enum logic [2:0] {IDLE, START, SYNC, SLOT, CONFIG} state_t;

    state_t                   state;
    logic [15:0]              stable_cnt;
    logic [31:0]              cyc_cnt;
    logic [P_CHANNEL_NUM-1:0] pending;
    logic [P_SLOT_ID_W-1:0]   slot_id;
    logic [31:0]              slot_cnt;
    logic                     slot_valid, reconfig, sim_start, link_err, sync_timeout;

    logic                     links_ok;
    logic [P_CHANNEL_NUM-1:0] remaining;
    logic [P_SLOT_ID_W-1:0]   next_id;

    assign links_ok  = &i_link_up;
    assign remaining = pending & ~i_sync_ready;
    assign next_id   = (slot_id == ID_LAST) ? '0 : slot_id + 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            stable_cnt   <= '0;
            cyc_cnt      <= '0;
            pending      <= '0;
            slot_id      <= '0;
            slot_cnt     <= '0;
            slot_valid   <= 1'b0;
            reconfig     <= 1'b0;
            sim_start    <= 1'b0;
            link_err     <= 1'b0;
            sync_timeout <= 1'b0;
        end else begin
            sim_start    <= 1'b0;
            link_err     <= 1'b0;
            sync_timeout <= 1'b0;
            // A dropped link aborts any active phase; slot_cnt is kept for diagnostics.
            if (state != IDLE && !links_ok) begin
                state      <= IDLE;
                link_err   <= 1'b1;
                slot_valid <= 1'b0;
                reconfig   <= 1'b0;
                pending    <= '0;
                slot_id    <= '0;
                stable_cnt <= '0;
                cyc_cnt    <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!links_ok) begin
                            stable_cnt <= '0;
                        end else if (stable_cnt == STABLE_LAST) begin
                            if (i_enable) begin
                                state      <= START;
                                sim_start  <= 1'b1;
                                slot_id    <= '0;
                                slot_cnt   <= '0;
                                stable_cnt <= '0;
                            end
                        end else begin
                            stable_cnt <= stable_cnt + 16'd1;
                        end
                    end
                    START: begin
                        state   <= SYNC;
                        pending <= '1;
                        cyc_cnt <= '0;
                    end
                    SYNC: begin
                        // Completion is checked first so it beats a coincident timeout.
                        if (remaining == '0) begin
                            pending    <= '0;
                            state      <= SLOT;
                            slot_valid <= 1'b1;
                            cyc_cnt    <= '0;
                        end else if (cyc_cnt == SYNC_LAST) begin
                            sync_timeout <= 1'b1;
                            pending      <= '0;
                            state        <= SLOT;
                            slot_valid   <= 1'b1;
                            cyc_cnt      <= '0;
                        end else begin
                            pending <= remaining;
                            cyc_cnt <= cyc_cnt + 32'd1;
                        end
                    end
                    SLOT: begin
                        if (cyc_cnt == SLOT_LAST) begin
                            slot_valid <= 1'b0;
                            slot_cnt   <= slot_cnt + 32'd1;
                            slot_id    <= next_id;
                            reconfig   <= 1'b1;
                            state      <= CONFIG;
                            cyc_cnt    <= '0;
                        end else begin
                            cyc_cnt <= cyc_cnt + 32'd1;
                        end
                    end
                    CONFIG: begin
                        if (cyc_cnt == CFG_LAST) begin
                            reconfig <= 1'b0;
                            cyc_cnt  <= '0;
                            if (i_enable) begin
                                state   <= SYNC;
                                pending <= '1;
                            end else begin
                                state      <= IDLE;
                                stable_cnt <= '0;
                            end
                        end else begin
                            cyc_cnt <= cyc_cnt + 32'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign o_sync_valid   = pending;
    assign o_sync_slot_id = slot_id;
    assign o_slot_id      = slot_id;
    assign o_slot_valid   = slot_valid;
    assign o_ocs_reconfig = reconfig;
    assign o_sim_start    = sim_start;
    assign o_link_err     = link_err;
    assign o_sync_timeout = sync_timeout;
    assign o_slot_cnt     = slot_cnt;

endmodule

// File: tb/tb_ocs_slot_sequencer.sv
// Directed bench for ocs_slot_sequencer; cycle n is the n-th clock after the last reset edge.
module tb_ocs_slot_sequencer;

    localparam int CH  = 4;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           enable = 1'b0;
    logic [CH-1:0]  link_up = '0;
    logic [CH-1:0]  sync_ready = '0;
    logic [CH-1:0]  sync_valid;
    logic [IDW-1:0] sync_slot_id, slot_id;
    logic           slot_valid, reconfig, sim_start, link_err, sync_timeout;
    logic [31:0]    slot_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    ocs_slot_sequencer #(
        .P_CHANNEL_NUM(CH), .P_SLOT_NUM(3), .P_SLOT_ID_W(IDW),
        .P_SLOT_LEN(32'd8), .P_CONFIG_DELAY(32'd3),
        .P_LINK_STABLE(16'd4), .P_SYNC_TIMEOUT(16'd6)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_enable(enable),
        .i_link_up(link_up), .i_sync_ready(sync_ready),
        .o_sync_valid(sync_valid), .o_sync_slot_id(sync_slot_id),
        .o_slot_id(slot_id), .o_slot_valid(slot_valid),
        .o_ocs_reconfig(reconfig), .o_sim_start(sim_start),
        .o_link_err(link_err), .o_sync_timeout(sync_timeout),
        .o_slot_cnt(slot_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic apply_reset();
        rst = 1'b1; enable = 1'b0; link_up = '0; sync_ready = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; link_up = '1; sync_ready = '1;
        repeat (3) step();
        checks++;
        if ({sim_start, slot_valid, reconfig, link_err, sync_timeout} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 00000", {sim_start, slot_valid, reconfig, link_err, sync_timeout});
        end
        checks++;
        if (sync_valid !== 4'h0) begin
            errors++; $display("FAIL reset_sync_valid: got %h want 0", sync_valid);
        end
        checks++;
        if (slot_id !== 2'd0 || sync_slot_id !== 2'd0) begin
            errors++; $display("FAIL reset_slot_id: got %0d/%0d want 0/0", slot_id, sync_slot_id);
        end
        checks++;
        if (slot_cnt !== 32'd0) begin
            errors++; $display("FAIL reset_slot_cnt: got %0d want 0", slot_cnt);
        end
    endtask

    task automatic test_basic();
        int starts, start_at, sv_cnt;
        int rise[$];
        logic [IDW-1:0] ids[$];
        logic prev_sv;
        starts = 0; start_at = -1; sv_cnt = 0; prev_sv = 1'b0;
        apply_reset();
        link_up = 4'hF; enable = 1'b1; sync_ready = 4'hF;
        repeat (44) begin
            step();
            if (sim_start) begin starts++; if (start_at < 0) start_at = cyc; end
            if (slot_valid && cyc <= 17) sv_cnt++;
            if (slot_valid && !prev_sv) begin rise.push_back(cyc); ids.push_back(slot_id); end
            prev_sv = slot_valid;
            if (cyc == 5) begin
                checks++;
                if (sync_valid !== 4'hF || sync_slot_id !== 2'd0) begin
                    errors++; $display("FAIL basic_sync_c5: got %h id %0d want F id 0", sync_valid, sync_slot_id);
                end
            end
            if (cyc == 14) begin
                checks++;
                if (reconfig !== 1'b1 || slot_valid !== 1'b0 || slot_id !== 2'd1 || slot_cnt !== 32'd1) begin
                    errors++;
                    $display("FAIL basic_config_c14: got rc=%b sv=%b id=%0d cnt=%0d want 1 0 1 1", reconfig, slot_valid, slot_id, slot_cnt);
                end
            end
            if (cyc == 16) begin
                checks++;
                if (reconfig !== 1'b1) begin errors++; $display("FAIL basic_config_c16: got %b want 1", reconfig); end
            end
            if (cyc == 17) begin
                checks++;
                if (reconfig !== 1'b0 || sync_valid !== 4'hF || sync_slot_id !== 2'd1) begin
                    errors++; $display("FAIL basic_sync_c17: got rc=%b sv=%h id=%0d want 0 F 1", reconfig, sync_valid, sync_slot_id);
                end
            end
        end
        checks++;
        if (starts != 1 || start_at != 4) begin
            errors++; $display("FAIL basic_start: got %0d pulses at %0d want 1 at 4", starts, start_at);
        end
        checks++;
        if (sv_cnt != 8) begin errors++; $display("FAIL basic_slot_len: got %0d want 8", sv_cnt); end
        checks++;
        if (rise.size() != 4 || rise[0] != 6 || rise[1] != 18 || rise[2] != 30 || rise[3] != 42) begin
            errors++; $display("FAIL basic_slot_starts: got %0d entries, first %0d want 6,18,30,42", rise.size(), (rise.size() > 0) ? rise[0] : -1);
        end
        checks++;
        if (ids.size() != 4 || ids[0] !== 2'd0 || ids[1] !== 2'd1 || ids[2] !== 2'd2 || ids[3] !== 2'd0) begin
            errors++; $display("FAIL basic_slot_ids: got %0d entries want 0,1,2,0", ids.size());
        end
        checks++;
        if (slot_cnt !== 32'd3) begin errors++; $display("FAIL basic_slot_cnt: got %0d want 3", slot_cnt); end
    endtask

    task automatic test_link_glitch();
        int start_at, lerr;
        start_at = -1; lerr = 0;
        apply_reset();
        link_up = 4'hF; enable = 1'b1; sync_ready = 4'hF;
        while (cyc < 14) begin
            step();
            if (cyc == 2) link_up = 4'hB;
            if (cyc == 3) link_up = 4'hF;
            if (sim_start && start_at < 0) start_at = cyc;
            if (link_err) lerr++;
        end
        checks++;
        if (start_at != 7) begin errors++; $display("FAIL glitch_start: got %0d want 7", start_at); end
        checks++;
        if (lerr != 0) begin errors++; $display("FAIL glitch_link_err: got %0d want 0", lerr); end
    endtask

    task automatic test_sync_timeout();
        int v3, to, to_at;
        v3 = 0; to = 0; to_at = -1;
        apply_reset();
        link_up = 4'hF; enable = 1'b1; sync_ready = 4'h7;
        while (cyc < 20) begin
            step();
            if (sync_valid[3]) v3++;
            if (sync_timeout) begin to++; to_at = cyc; end
            if (cyc == 6) begin
                checks++;
                if (sync_valid !== 4'h8) begin errors++; $display("FAIL timeout_pending: got %h want 8", sync_valid); end
            end
            if (cyc == 11) begin
                checks++;
                if (slot_valid !== 1'b1 || sync_valid !== 4'h0 || slot_cnt !== 32'd0) begin
                    errors++; $display("FAIL timeout_slot: got sv=%b v=%h cnt=%0d want 1 0 0", slot_valid, sync_valid, slot_cnt);
                end
            end
            if (cyc == 19) begin
                checks++;
                if (reconfig !== 1'b1 || slot_cnt !== 32'd1) begin
                    errors++; $display("FAIL timeout_config: got rc=%b cnt=%0d want 1 1", reconfig, slot_cnt);
                end
            end
        end
        checks++;
        if (v3 != 6) begin errors++; $display("FAIL timeout_valid_len: got %0d want 6", v3); end
        checks++;
        if (to != 1 || to_at != 11) begin errors++; $display("FAIL timeout_pulse: got %0d at %0d want 1 at 11", to, to_at); end
    endtask

    task automatic test_late_ready();
        int rise_at, to;
        rise_at = -1; to = 0;
        apply_reset();
        link_up = 4'hF; enable = 1'b1; sync_ready = 4'hD;
        while (cyc < 18) begin
            step();
            if (cyc == 8) begin
                checks++;
                if (sync_valid !== 4'h2) begin errors++; $display("FAIL late_pending: got %h want 2", sync_valid); end
                sync_ready = 4'hF;
            end
            if (slot_valid && rise_at < 0) rise_at = cyc;
            if (sync_timeout) to++;
            if (cyc == 17) begin
                checks++;
                if (reconfig !== 1'b1 || slot_valid !== 1'b0) begin
                    errors++; $display("FAIL late_config: got rc=%b sv=%b want 1 0", reconfig, slot_valid);
                end
            end
        end
        checks++;
        if (rise_at != 9) begin errors++; $display("FAIL late_slot_start: got %0d want 9", rise_at); end
        checks++;
        if (to != 0) begin errors++; $display("FAIL late_timeout: got %0d want 0", to); end
    endtask

    // Last straggler answers on the final SYNC cycle: completion must win.
    task automatic test_sync_edge();
        int rise_at, to;
        rise_at = -1; to = 0;
        apply_reset();
        link_up = 4'hF; enable = 1'b1; sync_ready = 4'hD;
        while (cyc < 14) begin
            step();
            if (cyc == 10) sync_ready = 4'hF;
            if (slot_valid && rise_at < 0) rise_at = cyc;
            if (sync_timeout) to++;
        end
        checks++;
        if (rise_at != 11 || to != 0) begin
            errors++; $display("FAIL edge_complete_vs_timeout: got slot@%0d timeouts %0d want 11 and 0", rise_at, to);
        end
    endtask

    task automatic test_link_loss();
        int lerr, restart_at;
        lerr = 0; restart_at = -1;
        apply_reset();
        link_up = 4'hF; enable = 1'b1; sync_ready = 4'hF;
        while (cyc < 31) begin
            step();
            if (link_err) lerr++;
            if (sim_start && cyc > 4 && restart_at < 0) restart_at = cyc;
            if (cyc == 20) begin
                checks++;
                if (slot_valid !== 1'b1 || slot_id !== 2'd1) begin
                    errors++; $display("FAIL loss_pre: got sv=%b id=%0d want 1 1", slot_valid, slot_id);
                end
                link_up = 4'hE;
            end
            if (cyc == 21) begin
                checks++;
                if (link_err !== 1'b1 || slot_valid !== 1'b0 || reconfig !== 1'b0 || sync_valid !== 4'h0 || slot_id !== 2'd0 || slot_cnt !== 32'd1) begin
                    errors++;
                    $display("FAIL loss_abort: got le=%b sv=%b rc=%b v=%h id=%0d cnt=%0d want 1 0 0 0 0 1", link_err, slot_valid, reconfig, sync_valid, slot_id, slot_cnt);
                end
            end
            if (cyc == 23) link_up = 4'hF;
        end
        checks++;
        if (lerr != 1) begin errors++; $display("FAIL loss_err_pulse: got %0d want 1", lerr); end
        checks++;
        if (restart_at != 27) begin errors++; $display("FAIL loss_restart: got %0d want 27", restart_at); end
    endtask

    task automatic test_enable_drop();
        int idle_act, restart_at;
        idle_act = 0; restart_at = -1;
        apply_reset();
        link_up = 4'hF; enable = 1'b1; sync_ready = 4'hF;
        while (cyc < 44) begin
            step();
            if (cyc == 9) enable = 1'b0;
            if (cyc >= 17 && cyc <= 30 && (sync_valid !== 4'h0 || slot_valid || reconfig || sim_start)) idle_act++;
            if (sim_start && cyc > 4 && restart_at < 0) restart_at = cyc;
            if (cyc == 16) begin
                checks++;
                if (reconfig !== 1'b1) begin errors++; $display("FAIL endrop_config_done: got %b want 1", reconfig); end
            end
            if (cyc == 20) begin
                checks++;
                if (slot_cnt !== 32'd1) begin errors++; $display("FAIL endrop_cnt: got %0d want 1", slot_cnt); end
            end
            if (cyc == 30) enable = 1'b1;
            if (cyc == 42) begin
                checks++;
                if (reconfig !== 1'b1 || slot_id !== 2'd1 || slot_cnt !== 32'd1) begin
                    errors++; $display("FAIL endrop_rerun: got rc=%b id=%0d cnt=%0d want 1 1 1", reconfig, slot_id, slot_cnt);
                end
                rst = 1'b1;
            end
            if (cyc == 43) begin
                checks++;
                if ({sim_start, slot_valid, reconfig, link_err, sync_timeout} !== 5'b0 || sync_valid !== 4'h0 ||
                    slot_id !== 2'd0 || sync_slot_id !== 2'd0 || slot_cnt !== 32'd0) begin
                    errors++;
                    $display("FAIL midrun_reset: got flags=%b v=%h id=%0d cnt=%0d want all 0",
                             {sim_start, slot_valid, reconfig, link_err, sync_timeout}, sync_valid, slot_id, slot_cnt);
                end
                rst = 1'b0;
            end
        end
        checks++;
        if (idle_act != 0) begin errors++; $display("FAIL endrop_idle_quiet: got %0d active cycles want 0", idle_act); end
        checks++;
        if (restart_at != 31) begin errors++; $display("FAIL endrop_restart: got %0d want 31", restart_at); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_link_glitch();
        test_sync_timeout();
        test_late_ready();
        test_sync_edge();
        test_link_loss();
        test_enable_drop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
